// File: rtl/mips_cpu_pkg.sv
// Shared constants for the MIPS CPU datapath: default widths and named register indices.
package mips_cpu_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 5;

  // Architectural register indices referenced by name in the datapath
  localparam int REG_ZERO = 0;
  localparam int REG_V0   = 2;
  localparam int REG_RA   = 31;

endpackage

// File: rtl/mips_cpu_regfile_read_port.sv
// One combinational read port: $0 forces zero, optional same-cycle write forwarding,
// otherwise the stored array word.
module mips_cpu_regfile_read_port
  import mips_cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = mips_cpu_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = mips_cpu_pkg::ADDR_WIDTH_DEF,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0] read_index,
  input  logic [DATA_WIDTH-1:0] array_word,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] read_data
);

  logic is_zero;
  logic bypass_hit;

  assign is_zero = (read_index == ADDR_WIDTH'(REG_ZERO));

  // Forward only a write that will actually commit at the next edge; reset drops it.
  // Index-0 writes never match here because is_zero takes precedence below.
  assign bypass_hit = WRITE_BYPASS && write_enable && !reset &&
                      (write_index == read_index);

  // Zero-select has priority over bypass, bypass over the array word
  always_comb begin
    read_data = array_word;
    if (is_zero)         read_data = '0;
    else if (bypass_hit) read_data = write_data;
  end

endmodule

// File: rtl/mips_cpu_regfile.sv
// 32x32 general-purpose register file feeding the shifter/ALU: two combinational
// read ports (rs -> op1, rt -> op2), one synchronous write port, $0 hardwired to zero,
// and a debug tap on $v0.
module mips_cpu_regfile
  import mips_cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = mips_cpu_pkg::DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH   = mips_cpu_pkg::ADDR_WIDTH_DEF,
  parameter bit WRITE_BYPASS = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] read_index_a,
  output logic [DATA_WIDTH-1:0] read_data_a,
  input  logic [ADDR_WIDTH-1:0] read_index_b,
  output logic [DATA_WIDTH-1:0] read_data_b,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] register_v0
);

  localparam int DEPTH     = 1 << ADDR_WIDTH;
  localparam int NUM_PORTS = 2;

  logic [DEPTH-1:0][DATA_WIDTH-1:0]     regs;
  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] rd_idx;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_word;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rd_data;

  // Storage: reset clears everything and wins over a same-cycle write; $0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      regs <= '0;
    end else if (write_enable && (write_index != ADDR_WIDTH'(REG_ZERO))) begin
      regs[write_index] <= write_data;
    end
  end

  // Port 0 is rs (op1 / shift amount), port 1 is rt (op2 / value shifted)
  assign rd_idx[0] = read_index_a;
  assign rd_idx[1] = read_index_b;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd
    assign rd_word[p] = regs[rd_idx[p]];

    mips_cpu_regfile_read_port #(
      .DATA_WIDTH  (DATA_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .WRITE_BYPASS(WRITE_BYPASS)
    ) u_port (
      .read_index  (rd_idx[p]),
      .array_word  (rd_word[p]),
      .write_enable(write_enable),
      .write_index (write_index),
      .write_data  (write_data),
      .reset       (reset),
      .read_data   (rd_data[p])
    );
  end

  assign read_data_a = rd_data[0];
  assign read_data_b = rd_data[1];

  // Debug tap shows the stored $v0 only, so a write appears one cycle after its edge
  assign register_v0 = regs[REG_V0];

endmodule

// File: doc/mips_cpu_regfile.md
Name: mips_cpu_regfile

Overview:
- General-purpose register file directly upstream of the shifter/ALU in the execute path.
- Supplies rs on read_data_a, which becomes op1. Variable shifts take their shift amount from it.
- Supplies rt on read_data_b, which becomes op2, the value that gets shifted.
- Holds 32 x 32-bit registers with $0 hardwired to zero. Accepts one write per cycle from writeback and exposes $v0 for the top-level debug/result port.

Parameters:
- DATA_WIDTH, 32, width of each register and of every data port.
- ADDR_WIDTH, 5, register index width; the depth is 2**ADDR_WIDTH.
- WRITE_BYPASS, 1, when 1 a same-cycle write is forwarded to the read ports; when 0 reads return the array contents only.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
- read_index_a  input  ADDR_WIDTH  rs index.
- read_data_a  output  DATA_WIDTH  rs value, feeds the shifter op1 / ALU operand A.
- read_index_b  input  ADDR_WIDTH  rt index.
- read_data_b  output  DATA_WIDTH  rt value, feeds the shifter op2 / ALU operand B.
- write_enable  input  1  commit write_data to write_index at the next edge.
- write_index  input  ADDR_WIDTH  destination register.
- write_data  input  DATA_WIDTH  writeback value.
- register_v0  output  DATA_WIDTH  registered copy of $2, for debug.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset: on a rising edge with reset=1, all 32 registers become 0, so register_v0=0 from the next cycle. Reset takes priority over a write in the same cycle; the write is dropped.
- Reads are combinational, with zero-cycle latency:
  - read_data_x = 0 if read_index_x == 0.
  - Otherwise, if WRITE_BYPASS=1 and write_enable=1 and reset=0 and write_index == read_index_x and write_index != 0, then read_data_x = write_data.
  - Otherwise read_data_x = regs[read_index_x].
- Both read ports are independent. Identical indices on both ports are legal and return the same value.
- Write: on a rising edge with reset=0, write_enable=1 and write_index != 0, set regs[write_index] = write_data. The new value is visible to non-bypassed reads from the following cycle.
- Writes to index 0 are silently discarded; reads of $0 always return 0, including when bypass would otherwise match.
- register_v0 always reflects the stored regs[2]. It is never bypassed, so a write to $2 shows on register_v0 one cycle after the write edge.
- No handshake: the block never stalls, and every write is accepted in a single cycle.
- No X propagation: all 32 registers are defined from the first reset onward. Behaviour before the first reset is unspecified.
- Reset mid-operation: while reset=1, read ports still return the array contents (pre-reset values on the first reset cycle, zeros afterwards), with bypass suppressed.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - DATA_WIDTH and ADDR_WIDTH defaults.
  - Named register indices: REG_ZERO=0, REG_V0=2, REG_RA=31.
- The bypass/zero-select read path is natural to implement once as sub-module mips_cpu_regfile_read_port, instantiated twice (ports a and b). The inputs to each instance are:
  - read index;
  - array word;
  - write enable, index and data;
  - reset.

Test Plan:
1. Reset, then read all indices 0..31 on both ports -> every read_data=0 and register_v0=0.
2. Write 0xDEADBEEF to $5, next cycle read_index_a=5 -> read_data_a=0xDEADBEEF; read_index_b=6 -> 0.
3. Same-cycle write 0x00000004 to $9 with read_index_a=9 (WRITE_BYPASS=1) -> read_data_a=0x00000004 in that same cycle. Repeat with WRITE_BYPASS=0 -> old value in that cycle, 0x00000004 in the next.
4. Write 0xFFFFFFFF to $0 -> read_data_a=read_data_b=0 in that cycle and all later cycles.
5. Write 0x12345678 to $2 -> register_v0 is 0 in the write cycle and 0x12345678 one cycle later; then assert reset with a simultaneous write of 0x1 to $3 -> $2 and $3 both read 0 after the edge.
6. Shifter-feed check: $8=0x80000000, $9=0x00000004, read_index_a=9, read_index_b=8 -> op1=0x00000004 and op2=0x80000000 as presented to the shifter.
